alu: RTL and testbench
======================

# alu

Combinational 32-bit integer ALU for the RV32I datapath, with a registered copy of the result for pipelined consumers. Takes an operation code and two 32-bit operands (`left`, `right`) and produces `result` within the same evaluation step. A single clocked output stage captures the result and a zero flag for downstream stages such as branch resolution and writeback.

## Interface
- `ALU_OP_LENGTH`, default 4: opcode width. Op constants come from the shared parameters header.
- `clk`  input  1  system clock; rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  capture enable for the output register stage.
- `opcode`  input  ALU_OP_LENGTH  operation select.
- `left`  input  32  operand A (rs1 / PC).
- `right`  input  32  operand B (rs2 / immediate).
- `result`  output  32  combinational result.
- `result_q`  output  32  registered result.
- `zero_q`  output  1  registered flag, 1 when the captured result is 0.

## Operation
- Op encodings:
  - ALU_OP_ADD = 0: left + right, modulo 2^32.
  - ALU_OP_SUB = 1: left − right, modulo 2^32.
  - ALU_OP_AND = 2: bitwise AND.
  - ALU_OP_OR = 3: bitwise OR.
  - ALU_OP_XOR = 4: bitwise XOR.
  - ALU_OP_SLL = 5: left << right[4:0].
  - ALU_OP_SRL = 6: logical right shift of left by right[4:0].
  - ALU_OP_SRA = 7: arithmetic right shift of left by right[4:0]; the sign of left[31] is replicated.
  - ALU_OP_SLT = 8: 32'd1 if signed(left) < signed(right), else 0.
  - ALU_OP_SLTU = 9: 32'd1 if unsigned(left) < unsigned(right), else 0.
  - ALU_OP_PASSB = 10: result = right (used for LUI).
- Unused encodings (11–15) produce result = 0.
- Arithmetic: no carry or overflow output. Overflow wraps silently.
- Shifts: only right[4:0] is used; right[31:5] is ignored.
- Fan-out: `result` is a pure function of (`opcode`, `left`, `right`). It contains no latches and does not depend on `clk`, `rst` or `en`.
- Register stage: on a rising `clk` edge with `en` = 1:
  - result_q ← result
  - zero_q ← (result == 0)
- With `en` = 0, both registers hold their value.
- Reset: `rst` = 1 forces result_q = 0 and zero_q = 1 immediately, without waiting for a clock edge. Both are held while `rst` is high.
- Reset does not affect `result`.

## Timing
- `result`: zero-cycle latency. It is valid after combinational settling from any input change. Benches sample it 1 time unit after changing the inputs.
- `result_q` / `zero_q`:
  - One-cycle latency: they reflect the inputs present at the rising edge where `en` = 1.
  - Visible after that edge.
- Reset mid-operation: an asserted `rst` overrides `en`. The first capture after `rst` deasserts happens at the next rising edge with `en` = 1.
- Simultaneous `rst` and clock edge: reset wins.
- Inputs change arbitrarily between edges. Only values at the rising edge are captured.

## Test plan
- ADD / AND / SUB, checked on `result` 1 time unit after the inputs are applied:
  - ADD, 4 + 3 → 7.
  - AND, 0b1100 & 0b1010 → 0b1000.
  - SUB, 7 − 3 → 4.
- Wrap and signed compare:
  - ADD, 0xFFFFFFFF + 1 → 0.
  - SUB, 0 − 1 → 0xFFFFFFFF.
  - SLT, 0xFFFFFFFF vs 1 → 1.
  - SLTU, 0xFFFFFFFF vs 1 → 0.
- Shifts:
  - SLL, 1 by 0x21 → 2 (only the low 5 bits of the amount are used).
  - SRL, 0x80000000 by 31 → 1.
  - SRA, 0x80000000 by 31 → 0xFFFFFFFF.
- Pass-through and undefined ops:
  - PASSB, right = 0x12345000 → 0x12345000.
  - Opcode 15 → 0.
  - OR, 0xF0 | 0x0F → 0xFF.
  - XOR, 0xFF ^ 0x0F → 0xF0.
- Register stage:
  - `en` = 1, ADD 4 + 3 at an edge → result_q = 7, zero_q = 0 after that edge.
  - `en` = 0, operands changed → result_q stays 7.
  - SUB 5 − 5 with `en` = 1 → zero_q = 1.
- Asynchronous reset:
  - Assert `rst` between edges → result_q = 0 and zero_q = 1 with no clock edge.
  - `result` is unaffected and still tracks the inputs.
  - After deassert, the next `en` = 1 edge captures normally.

Source files
------------

// File: rtl/alu.sv
// alu: combinational RV32I integer ALU with a registered result and zero flag
// for downstream consumers such as branch resolution and writeback.
module alu #(
    parameter int unsigned ALU_OP_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ALU_OP_LENGTH-1:0] opcode,
    input  logic [31:0]              left,
    input  logic [31:0]              right,
    output logic [31:0]              result,
    output logic [31:0]              result_q,
    output logic                     zero_q
);

    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_ADD   = ALU_OP_LENGTH'(0);
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SUB   = ALU_OP_LENGTH'(1);
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_AND   = ALU_OP_LENGTH'(2);
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_OR    = ALU_OP_LENGTH'(3);
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_XOR   = ALU_OP_LENGTH'(4);
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SLL   = ALU_OP_LENGTH'(5);
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SRL   = ALU_OP_LENGTH'(6);
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SRA   = ALU_OP_LENGTH'(7);
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SLT   = ALU_OP_LENGTH'(8);
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_SLTU  = ALU_OP_LENGTH'(9);
    localparam logic [ALU_OP_LENGTH-1:0] ALU_OP_PASSB = ALU_OP_LENGTH'(10);

    logic [4:0]  shamt;
    logic [31:0] result_d;
    logic        zero_d;

    assign shamt = right[4:0];

    // Operation decode; unused encodings yield zero.
    always_comb begin
        result = '0;
        unique case (opcode)
            ALU_OP_ADD:   result = left + right;
            ALU_OP_SUB:   result = left - right;
            ALU_OP_AND:   result = left & right;
            ALU_OP_OR:    result = left | right;
            ALU_OP_XOR:   result = left ^ right;
            ALU_OP_SLL:   result = left << shamt;
            ALU_OP_SRL:   result = left >> shamt;
            ALU_OP_SRA:   result = 32'($signed(left) >>> shamt);
            ALU_OP_SLT:   result = {31'b0, $signed(left) < $signed(right)};
            ALU_OP_SLTU:  result = {31'b0, left < right};
            ALU_OP_PASSB: result = right;
            default:      result = '0;
        endcase
    end

    // Next register state: capture on enable, otherwise hold.
    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        if (en) begin
            result_d = result;
            zero_d   = (result == '0);
        end
    end

    // Output register stage with asynchronous reset to an all-zero result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu with directed cases, a randomized
// reference-model run and register-stage / asynchronous-reset scenarios.
module tb_alu;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  opcode;
    logic [31:0] left;
    logic [31:0] right;
    logic [31:0] result;
    logic [31:0] result_q;
    logic        zero_q;

    int checks;
    int failures;

    alu #(.ALU_OP_LENGTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .opcode   (opcode),
        .left     (left),
        .right    (right),
        .result   (result),
        .result_q (result_q),
        .zero_q   (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model from the operation table using plain arithmetic.
    function automatic logic [31:0] ref_alu(input int unsigned op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        int unsigned sh;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[31] ? ua - 64'sd4294967296 : ua;
        sb = b[31] ? ub - 64'sd4294967296 : ub;
        sh = int'(ub % 32);
        case (op)
            0:  return 32'((ua + ub) % 64'sd4294967296);
            1:  return 32'((ua - ub + 64'sd4294967296) % 64'sd4294967296);
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return 32'((ua * (64'sd1 << sh)) % 64'sd4294967296);
            6:  return 32'(ua / (64'sd1 << sh));
            7:  return 32'((sa >= 0) ? sa / (64'sd1 << sh)
                                     : -((-sa + (64'sd1 << sh) - 1) / (64'sd1 << sh)));
            8:  return (sa < sb) ? 32'd1 : 32'd0;
            9:  return (ua < ub) ? 32'd1 : 32'd0;
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic apply(input int unsigned op, input logic [31:0] a, input logic [31:0] b);
        opcode = 4'(op);
        left   = a;
        right  = b;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (result_q !== 32'd0 || zero_q !== 1'b1) begin
            failures++;
            $display("FAIL reset_state result_q=%h zero_q=%b required result_q=00000000 zero_q=1",
                     result_q, zero_q);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int unsigned  ops [14] = '{0, 2, 1, 0, 1, 8, 9, 5, 6, 7, 10, 15, 3, 4};
        logic [31:0]  as  [14] = '{32'd4, 32'hC, 32'd7, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF,
                                   32'hFFFFFFFF, 32'd1, 32'h80000000, 32'h80000000,
                                   32'h0, 32'h1234, 32'hF0, 32'hFF};
        logic [31:0]  bs  [14] = '{32'd3, 32'hA, 32'd3, 32'd1, 32'd1, 32'd1, 32'd1, 32'h21,
                                   32'd31, 32'd31, 32'h12345000, 32'h5678, 32'h0F, 32'h0F};
        logic [31:0]  exp [14] = '{32'd7, 32'h8, 32'd4, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0,
                                   32'd2, 32'd1, 32'hFFFFFFFF, 32'h12345000, 32'd0,
                                   32'hFF, 32'hF0};
        for (int i = 0; i < 14; i++) begin
            apply(ops[i], as[i], bs[i]);
            checks++;
            if (result !== exp[i]) begin
                failures++;
                $display("FAIL directed_%0d op=%0d result=%h required=%h", i, ops[i], result, exp[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [31:0] exp_q;
        logic        exp_z;
        int unsigned op;
        exp_q = result_q;
        exp_z = zero_q;
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(15, 0);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(7, 0))
                0: b = a;
                1: a = 32'h80000000;
                2: b = 32'($urandom_range(40, 0));
                3: a = 32'hFFFFFFFF;
                default: ;
            endcase
            en = 1'($urandom_range(1, 0));
            apply(op, a, b);
            exp = ref_alu(op, a, b);
            checks++;
            if (result !== exp) begin
                failures++;
                $display("FAIL random_comb op=%0d a=%h b=%h result=%h required=%h", op, a, b, result, exp);
            end
            if (en) begin
                exp_q = exp;
                exp_z = (exp == 32'd0);
            end
            @(posedge clk);
            #1;
            checks++;
            if (result_q !== exp_q || zero_q !== exp_z) begin
                failures++;
                $display("FAIL random_reg en=%b result_q=%h zero_q=%b required %h %b",
                         en, result_q, zero_q, exp_q, exp_z);
            end
        end
    endtask

    task automatic test_register();
        en = 1'b1;
        apply(0, 32'd4, 32'd3);
        @(posedge clk);
        #1;
        checks++;
        if (result_q !== 32'd7 || zero_q !== 1'b0) begin
            failures++;
            $display("FAIL reg_capture result_q=%h zero_q=%b required 00000007 0", result_q, zero_q);
        end
        en = 1'b0;
        apply(1, 32'd9, 32'd9);
        @(posedge clk);
        #1;
        checks++;
        if (result_q !== 32'd7 || zero_q !== 1'b0) begin
            failures++;
            $display("FAIL reg_hold result_q=%h zero_q=%b required 00000007 0", result_q, zero_q);
        end
        en = 1'b1;
        apply(1, 32'd5, 32'd5);
        @(posedge clk);
        #1;
        checks++;
        if (result_q !== 32'd0 || zero_q !== 1'b1) begin
            failures++;
            $display("FAIL reg_zero result_q=%h zero_q=%b required 00000000 1", result_q, zero_q);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        apply(3, 32'h00AB0000, 32'h000000CD);
        @(posedge clk);
        #1;
        checks++;
        if (result_q !== 32'h00AB00CD) begin
            failures++;
            $display("FAIL pre_reset_capture result_q=%h required 00AB00CD", result_q);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (result_q !== 32'd0 || zero_q !== 1'b1) begin
            failures++;
            $display("FAIL async_reset result_q=%h zero_q=%b required 00000000 1", result_q, zero_q);
        end
        apply(0, 32'd100, 32'd23);
        checks++;
        if (result !== 32'd123) begin
            failures++;
            $display("FAIL comb_during_reset result=%h required 0000007b", result);
        end
        @(posedge clk);
        #1;
        checks++;
        if (result_q !== 32'd0 || zero_q !== 1'b1) begin
            failures++;
            $display("FAIL reset_overrides_en result_q=%h zero_q=%b required 00000000 1", result_q, zero_q);
        end
        rst = 1'b0;
        apply(10, 32'd0, 32'hDEAD0000);
        @(posedge clk);
        #1;
        checks++;
        if (result_q !== 32'hDEAD0000 || zero_q !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_capture result_q=%h zero_q=%b required DEAD0000 0", result_q, zero_q);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        en       = 1'b0;
        opcode   = '0;
        left     = '0;
        right    = '0;
        #2;
        test_reset();
        test_directed();
        test_register();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
